// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback register file.
// Used by wb_scoreboard and wb_regfile.
package wb_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     data_t;

   localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Provides source lookups for two read ports and the WAW check.
module wb_scoreboard
   import wb_pkg::*;
(
   input  logic      CLK,
   input  logic      RESET,
   input  logic      issue_valid,
   input  reg_addr_t issue_dest,
   input  logic      wb_valid,
   input  reg_addr_t wb_dest,
   input  reg_addr_t rd_a,
   input  reg_addr_t rd_b,
   output logic      busy_a,
   output logic      busy_b,
   output logic      waw
);

   logic [NUM_REGS-1:0] busy;
   logic                set_en;
   logic                clr_en;

   assign set_en = issue_valid && (issue_dest != ZERO_REG);
   assign clr_en = wb_valid && (wb_dest != ZERO_REG);

   // Set is applied last so a new producer wins over the retiring one
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         busy <= '0;
      end else begin
         if (clr_en) busy[wb_dest] <= 1'b0;
         if (set_en) busy[issue_dest] <= 1'b1;
      end
   end

   assign busy_a = busy[rd_a] && (rd_a != ZERO_REG);
   assign busy_b = busy[rd_b] && (rd_b != ZERO_REG);
   assign waw    = set_en && busy[issue_dest];

endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file with pending-write scoreboard and hazard stall.
// Define REGFILE_BYPASS_EN for same-cycle write-through on both read ports.
module wb_regfile
   import wb_pkg::*;
(
   input  logic      CLK,
   input  logic      RESET,
   input  logic      do_writeback1,
   input  reg_addr_t writeRegister1,
   input  data_t     writeData1,
   input  data_t     aluResult1,
   input  logic      MemtoReg1,
   input  reg_addr_t readRegisterA,
   input  reg_addr_t readRegisterB,
   input  logic      issue_valid,
   input  reg_addr_t issue_dest,
   output data_t     readDataA,
   output data_t     readDataB,
   output logic      busyA,
   output logic      busyB,
   output logic      stall
);

   data_t regs [NUM_REGS];
   data_t wdata;
   logic  wb_hit;
   logic  byp_a;
   logic  byp_b;
   logic  sb_busy_a;
   logic  sb_busy_b;
   logic  waw;

   assign wdata  = MemtoReg1 ? writeData1 : aluResult1;
   assign wb_hit = do_writeback1 && (writeRegister1 != ZERO_REG);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_hit) begin
         regs[writeRegister1] <= wdata;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign byp_a = wb_hit && (writeRegister1 == readRegisterA);
   assign byp_b = wb_hit && (writeRegister1 == readRegisterB);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   always_comb begin
      readDataA = regs[readRegisterA];
      if (readRegisterA == ZERO_REG) readDataA = '0;
      else if (byp_a)                readDataA = wdata;
   end

   always_comb begin
      readDataB = regs[readRegisterB];
      if (readRegisterB == ZERO_REG) readDataB = '0;
      else if (byp_b)                readDataB = wdata;
   end

   wb_scoreboard u_sb (
      .CLK         (CLK),
      .RESET       (RESET),
      .issue_valid (issue_valid),
      .issue_dest  (issue_dest),
      .wb_valid    (do_writeback1),
      .wb_dest     (writeRegister1),
      .rd_a        (readRegisterA),
      .rd_b        (readRegisterB),
      .busy_a      (sb_busy_a),
      .busy_b      (sb_busy_b),
      .waw         (waw)
   );

   // A bypassed source is already satisfied this cycle
   assign busyA = sb_busy_a && !byp_a;
   assign busyB = sb_busy_b && !byp_b;
   assign stall = busyA || busyB || waw;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed hazard scenarios, then random traffic
// checked against an array/flag reference model.
module tb_wb_regfile;
   import wb_pkg::*;

   logic      CLK = 1'b0;
   logic      RESET;
   logic      do_writeback1;
   reg_addr_t writeRegister1;
   data_t     writeData1;
   data_t     aluResult1;
   logic      MemtoReg1;
   reg_addr_t readRegisterA;
   reg_addr_t readRegisterB;
   logic      issue_valid;
   reg_addr_t issue_dest;
   data_t     readDataA;
   data_t     readDataB;
   logic      busyA;
   logic      busyB;
   logic      stall;

   int tests = 0;
   int fails = 0;

   logic [31:0] mregs [32];
   bit          mbusy [32];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   wb_regfile dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .do_writeback1  (do_writeback1),
      .writeRegister1 (writeRegister1),
      .writeData1     (writeData1),
      .aluResult1     (aluResult1),
      .MemtoReg1      (MemtoReg1),
      .readRegisterA  (readRegisterA),
      .readRegisterB  (readRegisterB),
      .issue_valid    (issue_valid),
      .issue_dest     (issue_dest),
      .readDataA      (readDataA),
      .readDataB      (readDataB),
      .busyA          (busyA),
      .busyB          (busyB),
      .stall          (stall)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] wd();
      return MemtoReg1 ? writeData1 : aluResult1;
   endfunction

   function automatic bit fwd(input logic [4:0] a);
      return BYP && do_writeback1 && writeRegister1 == a && a != 0;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (fwd(a)) return wd();
      return mregs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      return a != 0 && mbusy[a] && !fwd(a);
   endfunction

   function automatic logic exp_stall();
      return exp_busy(readRegisterA) || exp_busy(readRegisterB) ||
             (issue_valid && issue_dest != 0 && mbusy[issue_dest]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_rdA"},   readDataA, exp_rd(readRegisterA));
      chk({tag, "_rdB"},   readDataB, exp_rd(readRegisterB));
      chk({tag, "_busyA"}, 32'(busyA), 32'(exp_busy(readRegisterA)));
      chk({tag, "_busyB"}, 32'(busyB), 32'(exp_busy(readRegisterB)));
      chk({tag, "_stall"}, 32'(stall), 32'(exp_stall()));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         mregs[i] = 32'h0;
         mbusy[i] = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      if (do_writeback1 && writeRegister1 != 0) begin
         mregs[writeRegister1] = wd();
         mbusy[writeRegister1] = 1'b0;
      end
      if (issue_valid && issue_dest != 0) mbusy[issue_dest] = 1'b1;
      #1;
   endtask

   task automatic idle();
      do_writeback1  = 1'b0;
      writeRegister1 = 5'd0;
      writeData1     = 32'h0;
      aluResult1     = 32'h0;
      MemtoReg1      = 1'b0;
      issue_valid    = 1'b0;
      issue_dest     = 5'd0;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] alu,
                     input logic [31:0] mem, input logic m2r);
      do_writeback1  = 1'b1;
      writeRegister1 = r;
      aluResult1     = alu;
      writeData1     = mem;
      MemtoReg1      = m2r;
   endtask

   task automatic issue(input logic [4:0] r);
      issue_valid = 1'b1;
      issue_dest  = r;
   endtask

   initial begin
      RESET = 1'b1;
      idle();
      readRegisterA = 5'd0;
      readRegisterB = 5'd0;
      model_reset();
      #2;
      check_all("reset");
      #1 RESET = 1'b0;

      // 1: asynchronous reset wipes data and scoreboard between edges
      @(posedge CLK); #1;
      wb(5'd5, 32'hDEADBEEF, 32'h0, 1'b0);
      issue(5'd6);
      tick();
      idle();
      readRegisterA = 5'd5;
      readRegisterB = 5'd6;
      #1;
      check_all("t1_pre");
      chk("t1_r5", readDataA, 32'hDEADBEEF);
      chk("t1_busy6", 32'(busyB), 32'd1);
      RESET = 1'b1;
      #1;
      model_reset();
      chk("t1_rst_rdA", readDataA, 32'h0);
      check_all("t1_rst");
      #1 RESET = 1'b0;
      tick();

      // 2: write-data select
      wb(5'd3, 32'h12345678, 32'hFFFFFFFF, 1'b0);
      readRegisterA = 5'd3;
      #1 check_all("t2_wb_alu");
      tick();
      idle();
      #1 chk("t2_alu", readDataA, 32'h12345678);
      wb(5'd3, 32'h12345678, 32'hFFFFFFFF, 1'b1);
      tick();
      idle();
      #1 chk("t2_mem", readDataA, 32'hFFFFFFFF);
      check_all("t2_post");

      // 3: r0 is hardwired
      wb(5'd0, 32'hAAAA5555, 32'hAAAA5555, 1'b0);
      issue(5'd0);
      readRegisterA = 5'd0;
      #1 check_all("t3_cyc");
      tick();
      idle();
      #1;
      chk("t3_r0", readDataA, 32'h0);
      chk("t3_busy0", 32'(busyA), 32'd0);
      chk("t3_stall", 32'(stall), 32'd0);

      // 4: RAW stall released by writeback
      issue(5'd7);
      readRegisterA = 5'd7;
      readRegisterB = 5'd0;
      #1 check_all("t4_issue");
      tick();
      idle();
      for (int c = 0; c < 2; c++) begin
         #1 chk("t4_stall_wait", 32'(stall), 32'd1);
         tick();
      end
      wb(5'd7, 32'h0000CAFE, 32'h0, 1'b0);
      #1;
      chk("t4_wb_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
      chk("t4_wb_rdA", readDataA, BYP ? 32'h0000CAFE : 32'h0);
      check_all("t4_wb");
      tick();
      idle();
      #1;
      chk("t4_after_stall", 32'(stall), 32'd0);
      chk("t4_after_rdA", readDataA, 32'h0000CAFE);

      // 5: set wins over clear on the same register
      issue(5'd9);
      wb(5'd9, 32'h11, 32'h0, 1'b0);
      readRegisterA = 5'd0;
      readRegisterB = 5'd9;
      tick();
      idle();
      #1;
      chk("t5_r9", readDataB, 32'h11);
      chk("t5_busyB", 32'(busyB), 32'd1);
      check_all("t5_post");
      wb(5'd9, 32'h22, 32'h0, 1'b0);
      tick();
      idle();

      // 6: WAW stall on a second producer
      issue(5'd4);
      tick();
      issue(5'd4);
      readRegisterA = 5'd1;
      readRegisterB = 5'd2;
      #1 chk("t6_waw", 32'(stall), 32'd1);
      check_all("t6_waw_all");
      idle();
      wb(5'd4, 32'h44, 32'h0, 1'b0);
      tick();
      idle();
      issue(5'd4);
      #1 chk("t6_clear", 32'(stall), 32'd0);
      tick();
      idle();
      wb(5'd4, 32'h55, 32'h0, 1'b0);
      tick();
      idle();

      // Random traffic; decode never issues while stalled
      for (int n = 0; n < 400; n++) begin
         readRegisterA = 5'($urandom_range(0, 7));
         readRegisterB = 5'($urandom_range(0, 7));
         do_writeback1 = 1'($urandom_range(0, 1));
         writeRegister1 = 5'($urandom_range(0, 7));
         aluResult1 = $urandom;
         writeData1 = $urandom;
         MemtoReg1 = 1'($urandom_range(0, 1));
         issue_valid = 1'($urandom_range(0, 1));
         issue_dest = 5'($urandom_range(0, 7));
         if (exp_stall()) issue_valid = 1'b0;
         #1 check_all("rand");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
